// File: rtl/text_overlay_renderer_if.sv
// Pixel, buffer-write, font-ROM and text-output signals of text_overlay_renderer.
// The slave side is the renderer; the master side is the video/CPU/fontROM environment.
interface text_overlay_renderer_if #(
  parameter int ADDR_W = 6
);
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic              pix_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_char;
  logic              clear_req;
  logic              busy;
  logic [6:0]        font_char;
  logic [2:0]        font_row;
  logic [7:0]        font_data;
  logic              text_pixel;
  logic              text_valid;

  modport master (
    output pix_x, pix_y, pix_valid, wr_en, wr_addr, wr_char, clear_req, font_data,
    input  busy, font_char, font_row, text_pixel, text_valid
  );

  modport slave (
    input  pix_x, pix_y, pix_valid, wr_en, wr_addr, wr_char, clear_req, font_data,
    output busy, font_char, font_row, text_pixel, text_valid
  );
endinterface

// File: rtl/text_overlay_renderer.sv
// Character-cell text renderer: COLS x ROWS buffer, two-stage pixel pipeline
// feeding an external combinational fontROM, with a space-fill clear sweep.
module text_overlay_renderer #(
  parameter int COLS   = 16,
  parameter int ROWS   = 4,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int ADDR_W = 6
) (
  input logic                    clk,
  input logic                    reset,
  text_overlay_renderer_if.slave bus
);
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned COLS_U = COLS;
  localparam int unsigned WIN_W  = 8 * COLS;
  localparam int unsigned WIN_H  = 8 * ROWS;
  localparam logic [9:0]  X0_V   = 10'(X0);
  localparam logic [9:0]  Y0_V   = 10'(Y0);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [6:0]        mem_wdata;
  logic [6:0]        mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_char;
    unique case (state_q)
      S_IDLE: begin
        mem_we = bus.wr_en && (32'(bus.wr_addr) < CELLS);
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = 7'h20;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (32'(clr_cnt_q) == CELLS - 1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // 11-bit differences: bit 10 is the borrow, i.e. the pixel lies left of / above the window
  logic [10:0]       dx_ext, dy_ext;
  logic              in_box;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    dx_ext  = {1'b0, bus.pix_x} - {1'b0, X0_V};
    dy_ext  = {1'b0, bus.pix_y} - {1'b0, Y0_V};
    in_box  = !dx_ext[10] && (32'(dx_ext[9:0]) < WIN_W) &&
              !dy_ext[10] && (32'(dy_ext[9:0]) < WIN_H);
    rd_addr = ADDR_W'(32'(dy_ext[9:3]) * COLS_U + 32'(dx_ext[9:3]));
  end

  logic [6:0] char_q;
  logic [2:0] frow_q, bit_q;
  logic       box_q, vld_q, pix_q, tvld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      char_q <= '0;
      frow_q <= '0;
      bit_q  <= '0;
      box_q  <= 1'b0;
      vld_q  <= 1'b0;
      pix_q  <= 1'b0;
      tvld_q <= 1'b0;
    end else begin
      char_q <= mem_q[rd_addr];
      frow_q <= dy_ext[2:0];
      bit_q  <= dx_ext[2:0];
      box_q  <= in_box;
      vld_q  <= bus.pix_valid;
      pix_q  <= box_q & ~busy & bus.font_data[3'd7 - bit_q];
      tvld_q <= vld_q;
    end
  end

  assign bus.busy       = busy;
  assign bus.font_char  = char_q;
  assign bus.font_row   = frow_q;
  assign bus.text_pixel = pix_q;
  assign bus.text_valid = tvld_q;
endmodule
